// File: rtl/serial_out_arb.sv
// Round-robin arbiter that hands one serial output datapath to NUM_REQ requesters,
// sequencing start/run/stop/ack and generating the per-owner bit tick.
module serial_out_arb #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_BIT = 32,
    parameter int DIV_BIT  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_BIT-1:0]   i_data,
    input  logic [NUM_REQ*DIV_BIT-1:0]    i_div,
    input  logic                          i_abort,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_busy,
    output logic                          o_so_start,
    output logic                          o_so_stop,
    output logic                          o_so_mode,
    output logic                          o_so_tick,
    output logic [DATA_BIT-1:0]           o_so_data,
    input  logic                          i_so_done_tick
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      owner_q;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic [DATA_BIT-1:0]   data_q;
    logic [DIV_BIT-1:0]    div_q;
    logic [DIV_BIT-1:0]    cnt_q;
    logic                  ack_q;
    logic                  stop_q;
    logic                  run_stop;
    logic                  run_done;
    logic [NUM_REQ-1:0]    owner_hot;
    int                    cand;

    // Search starts just past the previous owner so it ends up with lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(last_q) + 1 + i) % NUM_REQ;
            if (!win_found && i_req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Abort or withdrawal by the owner outranks a simultaneous done tick.
    assign run_stop = (state_q == S_RUN) && (i_abort || !i_req[owner_q]);
    assign run_done = (state_q == S_RUN) && !run_stop && i_so_done_tick;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (run_stop || run_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= run_done;
            stop_q  <= run_stop;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        data_q  <= i_data[win_idx*DATA_BIT +: DATA_BIT];
                        div_q   <= i_div[win_idx*DIV_BIT +: DIV_BIT];
                    end
                end
                S_START: cnt_q <= '0;
                S_RUN:   cnt_q <= (cnt_q == div_q) ? '0 : cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign owner_hot  = NUM_REQ'(1) << owner_q;
    assign o_grant    = (state_q == S_START || state_q == S_RUN) ? owner_hot : '0;
    assign o_ack      = ack_q ? owner_hot : '0;
    assign o_busy     = (state_q != S_IDLE);
    assign o_so_start = (state_q == S_START);
    assign o_so_stop  = stop_q;
    assign o_so_mode  = 1'b0;
    assign o_so_tick  = (state_q == S_RUN) && (cnt_q == div_q);
    assign o_so_data  = data_q;

endmodule

// File: tb/tb_serial_out_arb.sv
// Directed bench for serial_out_arb: arbitration order, tick spacing, abort/withdraw,
// and asynchronous reset, with hand-computed expectations.
module tb_serial_out_arb;

    localparam int NR = 4;
    localparam int DB = 32;
    localparam int DV = 16;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     i_req;
    logic [NR*DB-1:0]  i_data;
    logic [NR*DV-1:0]  i_div;
    logic              i_abort;
    logic [NR-1:0]     o_grant;
    logic [NR-1:0]     o_ack;
    logic              o_busy;
    logic              o_so_start;
    logic              o_so_stop;
    logic              o_so_mode;
    logic              o_so_tick;
    logic [DB-1:0]     o_so_data;
    logic              i_so_done_tick;

    int total;
    int bad;

    serial_out_arb #(.NUM_REQ(NR), .DATA_BIT(DB), .DIV_BIT(DV)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_data         (i_data),
        .i_div          (i_div),
        .i_abort        (i_abort),
        .o_grant        (o_grant),
        .o_ack          (o_ack),
        .o_busy         (o_busy),
        .o_so_start     (o_so_start),
        .o_so_stop      (o_so_stop),
        .o_so_mode      (o_so_mode),
        .o_so_tick      (o_so_tick),
        .o_so_data      (o_so_data),
        .i_so_done_tick (i_so_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        i_req          = '0;
        i_abort        = 1'b0;
        i_so_done_tick = 1'b0;
        i_data         = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        i_div          = {16'd3, 16'd0, 16'd0, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", o_grant, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_so_start, 0);
        chk("rst_stop", o_so_stop, 0);
        chk("rst_tick", o_so_tick, 0);
        chk("rst_mode", o_so_mode, 0);
        chk("rst_data", o_so_data, 0);

        rst = 1'b0;
        step();
        chk("idle_busy", o_busy, 0);

        // Two requesters: 1 wins first, then 3 after the gap.
        i_req = 4'b1010;
        step();
        chk("rr1_grant", o_grant, 4'b0010);
        chk("rr1_start", o_so_start, 1);
        chk("rr1_data", o_so_data, 32'hB1B1_0001);
        chk("rr1_busy", o_busy, 1);
        step();
        chk("rr1_run_start", o_so_start, 0);
        chk("rr1_run_grant", o_grant, 4'b0010);
        chk("rr1_div0_tick", o_so_tick, 1);
        i_so_done_tick = 1'b1;
        step();
        i_so_done_tick = 1'b0;
        chk("rr1_ack", o_ack, 4'b0010);
        chk("rr1_gap_grant", o_grant, 0);
        chk("rr1_gap_stop", o_so_stop, 0);
        chk("rr1_gap_busy", o_busy, 1);
        step();
        chk("rr1_idle_ack", o_ack, 0);
        chk("rr1_idle_busy", o_busy, 0);
        chk("rr1_idle_grant", o_grant, 0);
        step();
        chk("rr3_grant", o_grant, 4'b1000);
        chk("rr3_start", o_so_start, 1);
        chk("rr3_data", o_so_data, 32'hD3D3_0003);

        // Divisor 3: tick on every 4th run cycle.
        step();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("div3_tick_c%0d", c), o_so_tick, (c % 4 == 3) ? 1 : 0);
            if (c < 7) step();
        end

        // Owner withdraws in the same cycle as done: stop wins, no ack.
        i_req          = 4'b0000;
        i_so_done_tick = 1'b1;
        step();
        i_so_done_tick = 1'b0;
        chk("wd_stop", o_so_stop, 1);
        chk("wd_ack", o_ack, 0);
        chk("wd_grant", o_grant, 0);
        chk("wd_busy", o_busy, 1);
        step();
        chk("wd_stop_off", o_so_stop, 0);
        chk("wd_busy_off", o_busy, 0);

        // All requesting: last owner was 3, so order is 0,1,2,3,0.
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            while (!o_so_start && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("all_start_%0d", j), o_so_start, 1);
            chk($sformatf("all_grant_%0d", j), o_grant, 4'b0001 << (j % 4));
            step();
            i_so_done_tick = 1'b1;
            step();
            i_so_done_tick = 1'b0;
            chk($sformatf("all_ack_%0d", j), o_ack, 4'b0001 << (j % 4));
            step();
            chk($sformatf("all_ack_off_%0d", j), o_ack, 0);
        end
        i_req = 4'b0000;

        // Abort: ignored in START, honoured in RUN; non-owner requests ignored.
        step();
        i_req = 4'b0001;
        step();
        chk("ab_grant", o_grant, 4'b0001);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("ab_start_ignored_grant", o_grant, 4'b0001);
        chk("ab_start_ignored_stop", o_so_stop, 0);
        i_req = 4'b0011;
        step();
        step();
        chk("ab_nonowner_grant", o_grant, 4'b0001);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("ab_stop", o_so_stop, 1);
        chk("ab_ack", o_ack, 0);
        chk("ab_grant_clr", o_grant, 0);
        chk("ab_busy_gap", o_busy, 1);
        i_req = 4'b0000;
        step();
        chk("ab_busy_off", o_busy, 0);
        chk("ab_stop_off", o_so_stop, 0);

        // Reset mid-run with requester 2 owning, then regrant to 2.
        i_req = 4'b0100;
        step();
        chk("rs_grant_start", o_grant, 4'b0100);
        step();
        chk("rs_grant_run", o_grant, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_grant", o_grant, 0);
        chk("rs_ack", o_ack, 0);
        chk("rs_busy", o_busy, 0);
        chk("rs_start", o_so_start, 0);
        chk("rs_stop", o_so_stop, 0);
        chk("rs_tick", o_so_tick, 0);
        chk("rs_data", o_so_data, 0);
        step();
        rst = 1'b0;
        step();
        chk("rs_regrant", o_grant, 4'b0100);
        chk("rs_regrant_start", o_so_start, 1);
        chk("rs_regrant_data", o_so_data, 32'hC2C2_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
